// File: rtl/weight_mem_ctrl.sv
// -----------------------------------------------------------------------------
// weight_mem_ctrl
//
// Sequencer and access controller for one neuron's weight memory.
//
// Write side: weight words arrive on the shared configuration bus. Words whose
// (cfg_layer, cfg_neuron) match this instance's (layerNo, neuronNo) are written
// to consecutive memory addresses 0..numWeight-1. Once the last address has
// been written, `loaded` rises. A later matching word written at address 0
// starts a reload, and `loaded` drops until the set is complete again.
//
// Read side: a `start` request with `loaded` set runs one read pass over every
// address. Each issued read is tagged one cycle later with w_valid, which lines
// up with the memory's registered read data. The final read is also tagged
// with w_last.
//
// Handshake (cfg bus): a word transfers on any rising edge where
// cfg_valid && cfg_ready. cfg_ready depends only on the FSM state and never on
// cfg_valid. Non-matching words are still accepted and then dropped, so this
// block never stalls the shared bus except while a read pass is in flight.
//
// Ports
//   clk, rst_n       clock; synchronous active-low reset
//   cfg_valid/ready  config bus handshake
//   cfg_layer/neuron target of the config word
//   cfg_data         weight value
//   start            request one read pass (needs loaded)
//   stall            downstream backpressure, suspends read issue in RUN
//   busy             pass in progress (state != IDLE)
//   loaded           full weight set present
//   done             one-cycle pulse in the final cycle of a pass
//   mem_wen/wadd/win memory write port
//   mem_ren/radd     memory read port
//   w_valid, w_last  read data qualifiers, one cycle after mem_ren
//   fsm_state        current FSM state (0 IDLE, 1 RUN, 2 DRAIN) for observation
// -----------------------------------------------------------------------------
module weight_mem_ctrl #(
  parameter int numWeight    = 3,
  parameter int neuronNo     = 5,
  parameter int layerNo      = 1,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [7:0]              cfg_layer,
  input  logic [7:0]              cfg_neuron,
  input  logic [dataWidth-1:0]    cfg_data,
  input  logic                    start,
  input  logic                    stall,
  output logic                    busy,
  output logic                    loaded,
  output logic                    done,
  output logic                    mem_wen,
  output logic [addressWidth-1:0] mem_wadd,
  output logic [dataWidth-1:0]    mem_win,
  output logic                    mem_ren,
  output logic [addressWidth-1:0] mem_radd,
  output logic                    w_valid,
  output logic                    w_last,
  output logic [1:0]              fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);
  localparam logic [addressWidth-1:0] ADDR_ONE  = addressWidth'(1);
  localparam logic [7:0]              MY_LAYER  = 8'(layerNo);
  localparam logic [7:0]              MY_NEURON = 8'(neuronNo);

  state_t                  state;
  state_t                  state_next;
  logic [addressWidth-1:0] wcnt;
  logic [addressWidth-1:0] wcnt_next;
  logic [addressWidth-1:0] rcnt;
  logic [addressWidth-1:0] rcnt_next;
  logic                    loaded_next;
  logic                    cfg_match;
  logic                    cfg_write;
  logic                    ren_core;

  // ---------------------------------------------------------------------------
  // Config side
  // ---------------------------------------------------------------------------
  assign cfg_ready = (state == IDLE);
  assign cfg_match = (cfg_layer == MY_LAYER) && (cfg_neuron == MY_NEURON);

  // Gated by rst_n so no write can reach memory while reset is asserted.
  assign cfg_write = rst_n && cfg_valid && cfg_ready && cfg_match;

  assign mem_wen  = cfg_write;
  assign mem_wadd = rst_n ? wcnt : '0;
  assign mem_win  = cfg_data;

  always_comb begin
    wcnt_next   = wcnt;
    loaded_next = loaded;
    if (cfg_write) begin
      if (wcnt == LAST_ADDR) begin
        // Last slot written: set is complete. The wrap check comes first so
        // a one-weight neuron still ends up loaded.
        wcnt_next   = '0;
        loaded_next = 1'b1;
      end else begin
        wcnt_next = wcnt + ADDR_ONE;
        // A write to address 0 begins a new set. Compute must not see a
        // half-replaced set, so loaded stays low until the wrap.
        if (wcnt == '0) begin
          loaded_next = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-pass FSM: next state and read issue
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    ren_core   = 1'b0;
    unique case (state)
      IDLE: begin
        // Uses the registered loaded: a reload that starts in this same cycle
        // does not cancel the pass being launched.
        if (start && loaded) begin
          state_next = RUN;
          rcnt_next  = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          ren_core  = 1'b1;
          rcnt_next = rcnt + ADDR_ONE;
          if (rcnt == LAST_ADDR) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Single cycle to line the done pulse up with the last w_valid.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_ren   = rst_n && ren_core;
  assign mem_radd  = rst_n ? rcnt : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == DRAIN);
  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      wcnt    <= '0;
      rcnt    <= '0;
      loaded  <= 1'b0;
      w_valid <= 1'b0;
      w_last  <= 1'b0;
    end else begin
      state   <= state_next;
      wcnt    <= wcnt_next;
      rcnt    <= rcnt_next;
      loaded  <= loaded_next;
      // Memory data is registered, so the valid/last tags trail the read
      // issue by exactly one cycle.
      w_valid <= ren_core;
      w_last  <= ren_core && (rcnt == LAST_ADDR);
    end
  end

endmodule
